// File: rtl/video_status_pio_in.sv
// Avalon-MM input PIO: synchronises WIDTH status lines, captures edges, raises a maskable level irq.
// Build option: define VIDEO_STATUS_PIO_IN_BITCLR_EN for write-1-to-clear on EDGECAP (else clear-all).

module video_status_pio_in_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    input  logic armed,
    input  logic clr,
    output logic sync_bit,
    output logic cap_bit
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   cap_q, cap_d;
    logic                   edge_det;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign cap_bit  = cap_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
        prev_d = sync_bit;
        if (EDGE_TYPE == 0)
            edge_det = sync_bit & ~prev_q;
        else if (EDGE_TYPE == 1)
            edge_det = ~sync_bit & prev_q;
        else
            edge_det = sync_bit ^ prev_q;
        edge_det = edge_det & armed;
        // A fresh edge overrides a clear in the same cycle so nothing is lost
        cap_d = (cap_q & ~clr) | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cap_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cap_q  <= cap_d;
        end
    end
endmodule

module video_status_pio_in #(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] sync_in, edge_cap, clr_vec;
    logic             armed, wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;
    assign armed        = (arm_cnt_q == ARM_DONE);
    assign wr_en        = chipselect & ~write_n;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        video_status_pio_in_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_TYPE   (EDGE_TYPE)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_bit   (in_port[g]),
            .armed    (armed),
            .clr      (clr_vec[g]),
            .sync_bit (sync_in[g]),
            .cap_bit  (edge_cap[g])
        );
    end

    always_comb begin
        // Counts edges since reset release; lines held high through reset settle before arming
        arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + 1'b1;
        irq_mask_d = irq_mask_q;
        clr_vec    = '0;
        if (wr_en && address == 2'd2)
            irq_mask_d = writedata[WIDTH-1:0];
        if (wr_en && address == 2'd3) begin
`ifdef VIDEO_STATUS_PIO_IN_BITCLR_EN
            clr_vec = writedata[WIDTH-1:0];
`else
            clr_vec = '1;
`endif
        end
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = sync_in;
            2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edge_cap;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_q  <= '0;
            irq_mask_q <= '0;
            readdata_q <= '0;
        end else begin
            arm_cnt_q  <= arm_cnt_d;
            irq_mask_q <= irq_mask_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap & irq_mask_q);
endmodule

// File: tb/tb_video_status_pio_in.sv
// Bench for video_status_pio_in: rising-edge and any-edge instances checked every cycle
// against a history-queue reference model, plus table vectors and directed corner sequences.

module tb_video_status_pio_in;
    localparam int W = 10;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd_rise, rd_any;
    logic          irq_rise, irq_any;

    always #5 clk = ~clk;

    video_status_pio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_rise), .irq(irq_rise)
    );

    video_status_pio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_any), .irq(irq_any)
    );

`ifdef VIDEO_STATUS_PIO_IN_BITCLR_EN
    localparam bit BITCLR = 1'b1;
`else
    localparam bit BITCLR = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: hist holds in_port as sampled at the last S+1 edges, oldest first
    logic [W-1:0] hist[$];
    int           arm_edges;
    logic [W-1:0] m_mask;
    logic [W-1:0] m_cap[2];
    logic [31:0]  m_rd[2];

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back('0);
        arm_edges = 0;
        m_mask    = '0;
        for (int k = 0; k < 2; k++) begin
            m_cap[k] = '0;
            m_rd[k]  = '0;
        end
    endtask

    task automatic model_step();
        logic [W-1:0] s, p, clr;
        logic [W-1:0] det[2];
        logic         wr;
        s      = hist[1];
        p      = hist[0];
        det[0] = (arm_edges >= S + 1) ? (s & ~p) : '0;
        det[1] = (arm_edges >= S + 1) ? (s ^ p)  : '0;
        wr     = chipselect && !write_n;
        clr    = '0;
        if (wr && address == 2'd3) clr = BITCLR ? writedata[W-1:0] : '1;
        for (int k = 0; k < 2; k++) begin
            case (address)
                2'd0:    m_rd[k] = 32'(s);
                2'd2:    m_rd[k] = 32'(m_mask);
                2'd3:    m_rd[k] = 32'(m_cap[k]);
                default: m_rd[k] = 32'd0;
            endcase
            m_cap[k] = (m_cap[k] & ~clr) | det[k];
        end
        if (wr && address == 2'd2) m_mask = writedata[W-1:0];
        hist.push_back(in_port);
        void'(hist.pop_front());
        if (arm_edges < S + 1) arm_edges++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        chk("rd_rise",  rd_rise, m_rd[0]);
        chk("irq_rise", 32'(irq_rise), 32'(|(m_cap[0] & m_mask)));
        chk("rd_any",   rd_any, m_rd[1]);
        chk("irq_any",  32'(irq_any), 32'(|(m_cap[1] & m_mask)));
    endtask

    task automatic tick();
        if (reset_n) model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_bus();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        idle_bus();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r0, output logic [31:0] r2);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        tick();
        r0 = rd_rise;
        r2 = rd_any;
        idle_bus();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rd_rise",  rd_rise, 32'd0);
        chk("rst_irq_rise", 32'(irq_rise), 32'd0);
        chk("rst_rd_any",   rd_any, 32'd0);
        chk("rst_irq_any",  32'(irq_any), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic clean();
        in_port = '0;
        repeat (5) tick();
        wr(2'd3, 32'h3FF);
        tick();
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_rise;
        logic [W-1:0] exp_any;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[6];
        logic [31:0] r0, r2;

        vecs[0] = '{10'h000, 10'h3FF, 10'h3FF, 10'h3FF};
        vecs[1] = '{10'h3FF, 10'h000, 10'h000, 10'h3FF};
        vecs[2] = '{10'h0F0, 10'h0FF, 10'h00F, 10'h00F};
        vecs[3] = '{10'h2AA, 10'h155, 10'h155, 10'h3FF};
        vecs[4] = '{10'h155, 10'h15F, 10'h00A, 10'h00A};
        vecs[5] = '{10'h300, 10'h0C0, 10'h0C0, 10'h3C0};

        // Lines held high through reset: no spurious capture
        reset_n = 1'b0; in_port = 10'h3FF; address = 2'd0; writedata = '0;
        idle_bus();
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
        repeat (10) tick();
        rd(2'd3, r0, r2);
        chk("held_cap_rise", r0, 32'h0);
        chk("held_cap_any",  r2, 32'h0);
        chk("held_irq",      32'(irq_rise | irq_any), 32'd0);
        rd(2'd0, r0, r2);
        chk("held_data", r0, 32'h3FF);

        // Capture latency on bit 0
        clean();
        wr(2'd2, 32'h001);
        address = 2'd0;
        in_port = 10'h001;
        tick();
        chk("lat_k",   32'(irq_rise), 32'd0);
        tick();
        chk("lat_k1",  32'(irq_rise), 32'd0);
        tick();
        chk("lat_k2",  32'(irq_rise), 32'd1);
        tick();
        chk("lat_data", 32'(rd_rise[0]), 32'd1);

        // Table vectors: edge pattern a -> b
        foreach (vecs[i]) begin
            in_port = vecs[i].a;
            repeat (5) tick();
            wr(2'd3, 32'h3FF);
            tick();
            in_port = vecs[i].b;
            repeat (5) tick();
            rd(2'd3, r0, r2);
            chk($sformatf("vec%0d_rise", i), r0, 32'(vecs[i].exp_rise));
            chk($sformatf("vec%0d_any", i),  r2, 32'(vecs[i].exp_any));
        end

        // Clear of bits 0 and 3 with writedata=1
        clean();
        in_port = 10'h009;
        repeat (5) tick();
        wr(2'd2, 32'h3FF);
        rd(2'd3, r0, r2);
        chk("clr_pre", r0, 32'h009);
        wr(2'd3, 32'h001);
        rd(2'd3, r0, r2);
        chk("clr_post_rise", r0, BITCLR ? 32'h008 : 32'h000);
        chk("clr_post_any",  r2, BITCLR ? 32'h008 : 32'h000);
        chk("clr_irq", 32'(irq_rise), BITCLR ? 32'd1 : 32'd0);

        // Clear and new edge on bit 2 in the same cycle: set wins
        clean();
        wr(2'd2, 32'h004);
        in_port = 10'h004;
        repeat (4) tick();
        in_port = 10'h000;
        repeat (4) tick();
        in_port = 10'h004;
        tick();
        tick();
        wr(2'd3, 32'h004);
        chk("setwin_irq_rise", 32'(irq_rise), 32'd1);
        chk("setwin_irq_any",  32'(irq_any),  32'd1);
        rd(2'd3, r0, r2);
        chk("setwin_cap_rise", r0, 32'h004);
        chk("setwin_cap_any",  r2, 32'h004);

        // Any-edge pulse with mask 0, then unmask
        clean();
        wr(2'd2, 32'h000);
        in_port = 10'h020;
        repeat (4) tick();
        in_port = 10'h000;
        repeat (5) tick();
        rd(2'd3, r0, r2);
        chk("pulse_cap_any", r2, 32'h020);
        chk("pulse_irq_any", 32'(irq_any), 32'd0);
        wr(2'd2, 32'h020);
        chk("unmask_irq_any", 32'(irq_any), 32'd1);

        // Reset mid-operation with captures pending
        clean();
        in_port = 10'h0FF;
        repeat (5) tick();
        wr(2'd2, 32'h3FF);
        chk("pre_rst_irq", 32'(irq_rise), 32'd1);
        rd(2'd3, r0, r2);
        chk("pre_rst_cap", r0, 32'h0FF);
        pulse_reset();
        repeat (S + 1) tick();
        wr(2'd2, 32'h3FF);
        repeat (6) tick();
        rd(2'd3, r0, r2);
        chk("post_rst_cap_rise", r0, 32'h0);
        chk("post_rst_cap_any",  r2, 32'h0);
        chk("post_rst_irq", 32'(irq_rise | irq_any), 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 5) != 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            if (i == 750) pulse_reset();
            tick();
        end
        idle_bus();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/video_status_pio_in.md
Name: video_status_pio_in

Overview:
- Avalon-MM slave input PIO that carries WIDTH status lines from video-pipeline hardware into the Nios/CPU domain.
- It is the receive-direction counterpart to the existing output PIO, which drives control bits from CPU to fabric.
- Synchronises the inputs, detects edges, latches them in a sticky edge-capture register and raises a maskable level interrupt.
- Reads have a fixed latency of 1 cycle.

Parameters:
- WIDTH, 10, number of input lines (1..32).
- SYNC_STAGES, 2, flip-flop synchroniser depth on in_port (2..4).
- EDGE_TYPE, 0, edge detected: 0 rising, 1 falling, 2 any.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous status lines from fabric.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt to CPU.

Behaviour:
- Register map:
  - 0 DATA: synchronised in_port. Read-only; writes ignored.
  - 1: reserved. Reads 0; writes ignored.
  - 2 IRQMASK: WIDTH bits, R/W.
  - 3 EDGECAP: WIDTH bits, sticky. Read returns the latched edges; write clears.
- Reset values: sync chain, prev, irq_mask, edge_capture, readdata all 0; irq 0; arm counter 0.
- Synchroniser:
  - in_port passes through SYNC_STAGES flops to give sync_in.
  - prev holds sync_in delayed 1 cycle.
- Edge detect, per bit:
  - rise = sync_in & ~prev.
  - fall = ~sync_in & prev.
  - any = sync_in ^ prev.
  - EDGE_TYPE selects which of these is used.
- Arming:
  - After reset_n deasserts, a counter counts SYNC_STAGES+1 clk edges.
  - Edge detection is forced to 0 until the count completes. Lines held high through reset therefore produce no spurious capture.
  - Once armed, the block stays armed until the next reset.
- Latency:
  - An in_port transition meeting setup before clk edge k shows in DATA reads sampled at edge k+SYNC_STAGES-1.
  - The corresponding edge_capture bit sets at edge k+SYNC_STAGES.
- Write decode: chipselect && !write_n, using writedata[WIDTH-1:0].
  - address 2 loads irq_mask.
  - address 3 clears edge_capture (clear rule depends on the optional feature).
- Simultaneous set/clear on the same bit in the same cycle: the set wins, so no edge is lost.
- An edge on a bit that is already set leaves it set; there is no counting.
- Read path:
  - Every clk edge, readdata is registered from the mux on the current address.
  - Zero-extended to 32 bits; address 1 returns 0.
  - Read latency is 1. No read strobe is used, and reads have no side effects.
- irq:
  - irq = |(edge_capture & irq_mask), combinational from registers.
  - Asserts in the same cycle the captured bit becomes visible.
  - Deasserts the cycle after a clear or mask write takes effect.
- Mask behaviour: capture is unaffected by the mask. Unmasking a bit that is already captured asserts irq immediately.
- Asynchronous reset mid-operation:
  - Clears all state immediately and disarms the block.
  - Edges in flight are discarded.

Optional Feature:
- Macro: VIDEO_STATUS_PIO_IN_BITCLR_EN.
- Defined: a write to address 3 clears only the edge_capture bits where writedata is 1 (write-1-to-clear). Other bits are retained.
- Undefined: any write to address 3 clears all edge_capture bits, regardless of writedata.
- The set-wins rule applies in both builds.

Test Plan:
- Reset with in_port=10'h3FF held, release, wait 10 cycles -> EDGECAP reads 0, irq=0, DATA reads 10'h3FF.
- EDGE_TYPE=0, irq_mask=10'h001; toggle in_port[0] 0->1 at edge k -> edge_capture[0]=1 and irq=1 at edge k+2; DATA read issued the next cycle returns bit0=1 one cycle later.
- Capture bits 0 and 3 (EDGECAP=10'h009); write 10'h001 to address 3 -> BITCLR_EN build reads 10'h008, non-BITCLR build reads 10'h000; irq follows the masked result.
- Write-clear of bit 2 in the same cycle a new rising edge on bit 2 is detected -> bit 2 remains 1 and irq stays asserted.
- EDGE_TYPE=2, mask 0: pulse in_port[5] high for 4 cycles -> EDGECAP=10'h020, irq=0; then write mask 10'h020 -> irq=1 on the next cycle.
- Assert reset_n low for 1 cycle while EDGECAP=10'h0FF and irq=1 -> all outputs 0 immediately; no capture occurs for SYNC_STAGES+1 cycles after release.
